// File: rtl/adc_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : adc_pkg
// Description : Shared constants, FSM encoding and config-word builder for the
//               serial SAR ADC scan sequencer.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
package adc_pkg;

    localparam int NUM_CH = 8;
    localparam int CFG_W  = 6;

    // Bit positions inside the 6-bit config word (bit 5 is shifted first)
    localparam int CFG_BIT_SD  = 5;
    localparam int CFG_BIT_OS  = 4;
    localparam int CFG_BIT_S1  = 3;
    localparam int CFG_BIT_S0  = 2;
    localparam int CFG_BIT_UNI = 1;
    localparam int CFG_BIT_SLP = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } adc_state_e;

    function automatic logic [CFG_W-1:0] cfg_word(input logic [2:0] ch, input logic unipolar);
        logic [CFG_W-1:0] w;
        w              = '0;
        w[CFG_BIT_SD]  = 1'b1;
        w[CFG_BIT_OS]  = ch[0];
        w[CFG_BIT_S1]  = ch[2];
        w[CFG_BIT_S0]  = ch[1];
        w[CFG_BIT_UNI] = unipolar;
        w[CFG_BIT_SLP] = 1'b0;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_serial_shifter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : adc_serial_shifter
// Description : SCK phase generator with combined SDI config shift-out and SDO
//               capture; start loads the config, done flags the last SDO bit.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module adc_serial_shifter
    import adc_pkg::*;
#(
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [CFG_W-1:0]  i_cfg,
    input  logic              i_sdo,
    output logic              o_sck,
    output logic              o_sdi,
    output logic              o_done,
    output logic [DATA_W-1:0] o_data
);

    localparam int c_CNT_W = $clog2(2 * DATA_W);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(2 * DATA_W - 1);

    logic               r_active_q, w_active_d;
    logic [c_CNT_W-1:0] r_cnt_q,    w_cnt_d;
    logic [CFG_W-1:0]   r_tx_q,     w_tx_d;
    logic [DATA_W-2:0]  r_rx_q,     w_rx_d;
    logic               r_sck_q,    w_sck_d;
    logic               r_sdi_q,    w_sdi_d;
    logic               w_last;

    assign w_last = r_active_q && (r_cnt_q == c_LAST);

    // Even steps drive SCK low and present the next SDI bit; odd steps raise
    // SCK and capture SDO on that same edge.
    always_comb begin
        w_active_d = r_active_q;
        w_cnt_d    = r_cnt_q;
        w_tx_d     = r_tx_q;
        w_rx_d     = r_rx_q;
        w_sck_d    = 1'b0;
        w_sdi_d    = 1'b0;
        if (i_start) begin
            w_active_d = 1'b1;
            w_cnt_d    = '0;
            w_tx_d     = i_cfg;
            w_rx_d     = '0;
        end else if (r_active_q) begin
            w_cnt_d = r_cnt_q + 1'b1;
            if (w_last) begin
                w_active_d = 1'b0;
            end
            if (!r_cnt_q[0]) begin
                w_sdi_d = r_tx_q[CFG_W-1];
                w_tx_d  = {r_tx_q[CFG_W-2:0], 1'b0};
            end else begin
                w_sck_d = 1'b1;
                w_sdi_d = r_sdi_q;
                w_rx_d  = {r_rx_q[DATA_W-3:0], i_sdo};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active_q <= 1'b0;
            r_cnt_q    <= '0;
            r_tx_q     <= '0;
            r_rx_q     <= '0;
            r_sck_q    <= 1'b0;
            r_sdi_q    <= 1'b0;
        end else begin
            r_active_q <= w_active_d;
            r_cnt_q    <= w_cnt_d;
            r_tx_q     <= w_tx_d;
            r_rx_q     <= w_rx_d;
            r_sck_q    <= w_sck_d;
            r_sdi_q    <= w_sdi_d;
        end
    end

    assign o_sck  = r_sck_q;
    assign o_sdi  = r_sdi_q;
    assign o_done = w_last;
    assign o_data = {r_rx_q, i_sdo};

endmodule
`default_nettype wire

// File: rtl/adc_scan_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : adc_scan_sequencer
// Description : Round-robin frame engine for an 8-channel serial SAR ADC with
//               pipelined channel config and tagged single-cycle results.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module adc_scan_sequencer
    import adc_pkg::*;
#(
    parameter int DATA_W       = 12,
    parameter int CONV_CYCLES  = 2,
    parameter int FRAME_CYCLES = 40,
    parameter bit UNIPOLAR     = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic              adc_convst,
    output logic              adc_sck,
    output logic              adc_sdi,
    input  logic              adc_sdo,
    output logic              sample_valid,
    output logic [DATA_W-1:0] sample_data,
    output logic [2:0]        sample_ch,
    output logic              busy
);

    localparam int c_CNT_W = $clog2(FRAME_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CONV_LAST  = c_CNT_W'(CONV_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_SHIFT_LAST = c_CNT_W'(CONV_CYCLES + 2 * DATA_W - 1);
    localparam logic [c_CNT_W-1:0] c_FRAME_LAST = c_CNT_W'(FRAME_CYCLES - 1);

    localparam logic [1:0] c_IDLE  = 2'(ST_IDLE);
    localparam logic [1:0] c_CONV  = 2'(ST_CONV);
    localparam logic [1:0] c_SHIFT = 2'(ST_SHIFT);
    localparam logic [1:0] c_GAP   = 2'(ST_GAP);

    generate
        if (FRAME_CYCLES < CONV_CYCLES + 2 * DATA_W + 1) begin : g_frame_check
            $error("FRAME_CYCLES too small for CONV_CYCLES + 2*DATA_W + 1");
        end
    endgenerate

    // Lowest set mask bit at or after 'start', wrapping; the caller guarantees mask != 0.
    function automatic logic [2:0] f_next_ch(input logic [NUM_CH-1:0] mask,
                                             input logic [2:0] start);
        logic [2:0] idx;
        f_next_ch = start;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = start + 3'(i);
            if (mask[idx]) f_next_ch = idx;
        end
    endfunction

    logic [1:0]         r_state_q,  w_state_d;
    logic [c_CNT_W-1:0] r_cnt_q,    w_cnt_d;
    logic [2:0]         r_cur_ch_q, w_cur_ch_d;
    logic [2:0]         r_tag_ch_q, w_tag_ch_d;
    logic               r_prime_q,  w_prime_d;
    logic               r_valid_q,  w_valid_d;
    logic [DATA_W-1:0]  r_data_q,   w_data_d;
    logic [2:0]         r_sch_q,    w_sch_d;

    logic              w_frame_go;
    logic              w_shift_start;
    logic              w_shift_done;
    logic [DATA_W-1:0] w_shift_data;

    assign w_frame_go    = enable && (|ch_mask);
    assign w_shift_start = (r_state_q == c_CONV) && (r_cnt_q == c_CONV_LAST);

    always_comb begin
        w_state_d  = r_state_q;
        w_cnt_d    = r_cnt_q;
        w_cur_ch_d = r_cur_ch_q;
        w_tag_ch_d = r_tag_ch_q;
        w_prime_d  = r_prime_q;
        case (r_state_q)
            c_IDLE: begin
                if (w_frame_go) begin
                    w_state_d  = c_CONV;
                    w_cnt_d    = '0;
                    w_prime_d  = 1'b1;
                    w_cur_ch_d = f_next_ch(ch_mask, 3'd0);
                end
            end
            c_CONV: begin
                w_cnt_d = r_cnt_q + 1'b1;
                if (r_cnt_q == c_CONV_LAST) w_state_d = c_SHIFT;
            end
            c_SHIFT: begin
                w_cnt_d = r_cnt_q + 1'b1;
                if (r_cnt_q == c_SHIFT_LAST) w_state_d = c_GAP;
            end
            c_GAP: begin
                if (r_cnt_q == c_FRAME_LAST) begin
                    w_cnt_d = '0;
                    if (w_frame_go) begin
                        // The channel configured this frame converts next frame.
                        w_state_d  = c_CONV;
                        w_prime_d  = 1'b0;
                        w_tag_ch_d = r_cur_ch_q;
                        w_cur_ch_d = f_next_ch(ch_mask, r_cur_ch_q + 3'd1);
                    end else begin
                        w_state_d  = c_IDLE;
                        w_cur_ch_d = '0;
                    end
                end else begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
            end
            default: begin
                w_state_d = c_IDLE;
                w_cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        w_valid_d = w_shift_done && !r_prime_q;
        w_data_d  = w_valid_d ? w_shift_data : r_data_q;
        w_sch_d   = w_valid_d ? r_tag_ch_q   : r_sch_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q  <= c_IDLE;
            r_cnt_q    <= '0;
            r_cur_ch_q <= '0;
            r_tag_ch_q <= '0;
            r_prime_q  <= 1'b0;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
            r_sch_q    <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_cnt_q    <= w_cnt_d;
            r_cur_ch_q <= w_cur_ch_d;
            r_tag_ch_q <= w_tag_ch_d;
            r_prime_q  <= w_prime_d;
            r_valid_q  <= w_valid_d;
            r_data_q   <= w_data_d;
            r_sch_q    <= w_sch_d;
        end
    end

    adc_serial_shifter #(
        .DATA_W (DATA_W)
    ) u_shifter (
        .clk     (clk),
        .rst     (reset),
        .i_start (w_shift_start),
        .i_cfg   (cfg_word(r_cur_ch_q, UNIPOLAR)),
        .i_sdo   (adc_sdo),
        .o_sck   (adc_sck),
        .o_sdi   (adc_sdi),
        .o_done  (w_shift_done),
        .o_data  (w_shift_data)
    );

    assign adc_convst   = (r_state_q == c_CONV);
    assign busy         = (r_state_q != c_IDLE);
    assign sample_valid = r_valid_q;
    assign sample_data  = r_data_q;
    assign sample_ch    = r_sch_q;

endmodule
`default_nettype wire
